fp_wb_arbiter: RTL and testbench
================================

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter CONFIG, default EXAMPLE_CONFIG, meaning the core configuration (cpu_config_t).
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning the number of FP intermediate writeback sources (range 2..4).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port src_valid, input, NUM_SRC, meaning source i presents a result.
REQ-006 SHALL have port src_ack, output, NUM_SRC, meaning source i's result is accepted this cycle.
REQ-007 SHALL have port src_id, input, NUM_SRC x id_t, the instruction id per source.
REQ-008 SHALL have port src_data, input, NUM_SRC x fp_wb_payload_t, the pre-normalization result per source.
REQ-009 SHALL have port out_valid, output, 1, meaning the output register holds a result.
REQ-010 SHALL have port out_ready, input, 1, meaning the downstream normalize/round stage accepts this cycle.
REQ-011 SHALL have port out_id, output, id_t, the id of the held result.
REQ-012 SHALL have port out_data, output, fp_wb_payload_t, the held result.

Function
REQ-013 SHALL use a one-entry output register: load_en = ~out_valid | out_ready.
REQ-014 SHALL grant at most one source per cycle, and only when load_en=1 and that source's src_valid=1.
REQ-015 SHALL assert src_ack[i] combinationally in the grant cycle; src_ack is one-hot or zero, and never asserted for an invalid source.
REQ-016 SHALL capture src_id/src_data of the granted source at the next edge and set out_valid=1; latency is exactly 1 cycle from ack to out_valid.
REQ-017 SHALL, when load_en=1 and no source is valid, clear out_valid at the edge.
REQ-018 SHALL hold out_id/out_data/out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL arbitrate round-robin: priority pointer ptr (clog2(NUM_SRC) bits); the highest-priority source is ptr, then ptr+1, and so on, modulo NUM_SRC.
REQ-020 SHALL set ptr to (granted index + 1) mod NUM_SRC after each grant; ptr is unchanged when there is no grant.
REQ-021 SHALL sustain 1 result/cycle with out_ready held high (a simultaneous drain and load is allowed).
REQ-022 SHALL guarantee that a continuously valid source is acked within NUM_SRC grant cycles.
REQ-023 SHALL require sources to hold src_valid/src_id/src_data stable until acked; the arbiter does not check this.
REQ-024 SHALL keep ack to a source independent of that source's own ack (no combinational loop src_valid->src_ack->src_valid).

Reset
REQ-025 SHALL set out_valid=0 and ptr=0 on rst; out_id and out_data are don't-care.
REQ-026 SHALL drive src_ack=0 during any cycle with rst=1; a held result is discarded by reset mid-operation.

Structure
REQ-027 SHALL define fp_wb_payload_t (sign, exponent, mantissa, guard/round/sticky, flags) in fpu_types; id_t comes from cva5_types.
REQ-028 SHALL place the combinational rotate-priority grant in one sub-module, fp_wb_rr_select (inputs: request vector, ptr; output: one-hot grant).

Verification
REQ-029 SHALL cover this scenario: after reset, src_valid=2'b11 and out_ready=1 for 4 cycles -> acks 01,10,01,10; out_id follows the source ids; ptr alternates.
REQ-030 SHALL cover this scenario: out_valid=1, out_ready=0 for 3 cycles with src_valid=2'b01 -> src_ack=0 and out_data stable; on ready, ack[0] is issued the same cycle.
REQ-031 SHALL cover this scenario: only src1 is valid with ids 5,6,7 back-to-back and ready=1 -> out_id 5,6,7 on consecutive cycles, with no bubble.
REQ-032 SHALL cover this scenario: rst asserted while out_valid=1 and src_valid=2'b10 -> next cycle out_valid=0, ptr=0, src_ack=0 during reset.
REQ-033 SHALL cover this scenario: NUM_SRC=3, all valid, ready=1 -> grant order 0,1,2,0; no source waits more than 3 grants.
REQ-034 SHALL cover this scenario: no source valid, out_valid=1, out_ready=1 -> out_valid=0 next cycle, ptr unchanged.

Source files
------------

// File: rtl/cva5_types.sv
// Core-wide types shared by the CVA5 pipeline blocks.
// Provides the instruction id type and the core configuration record.
// No logic; types and constants only.
package cva5_types;

  localparam int LOG2_MAX_IDS = 3;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;

  typedef struct packed {
    logic       include_fpu;
    logic [3:0] fpu_wb_ports;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{
    include_fpu:  1'b1,
    fpu_wb_ports: 4'd2
  };

endpackage

// File: rtl/fpu_types.sv
// FPU datapath types.
// Pre-normalization writeback payload carried from the FP units to normalize/round.
// No logic; types only.
package fpu_types;

  localparam int FP_EXP_W  = 11;
  localparam int FP_MANT_W = 53;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exponent;
    logic [FP_MANT_W-1:0] mantissa;
    logic                 guard;
    logic                 round;
    logic                 sticky;
    logic [4:0]           flags;
  } fp_wb_payload_t;

endpackage

// File: rtl/fp_wb_rr_select.sv
// Rotating-priority one-hot select: first requester at or after ptr wins.
// Purely combinational, zero latency.
// No backpressure; the caller masks req when it cannot accept.
module fp_wb_rr_select #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant
);

  // Scan from ptr upward with wrap-around; the first active request is granted.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin merge of FP intermediate writeback sources into one output register.
// Latency: 1 cycle from src_ack to out_valid; sustains one result per cycle.
// Backpressure: out_ready low holds the register and suppresses all acks.
module fp_wb_arbiter
  import cva5_types::*;
  import fpu_types::*;
#(
  parameter cpu_config_t CONFIG  = EXAMPLE_CONFIG,
  parameter int          NUM_SRC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NUM_SRC-1:0] src_valid,
  output logic [NUM_SRC-1:0] src_ack,
  input  id_t            src_id   [NUM_SRC],
  input  fp_wb_payload_t src_data [NUM_SRC],
  output logic           out_valid,
  input  logic           out_ready,
  output id_t            out_id,
  output fp_wb_payload_t out_data
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic               load_en;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   gnt_idx;

  // The register can take a new result when empty or draining this cycle.
  assign load_en = ~out_valid | out_ready;

  // Requests are masked during reset and stall so acks can never fire then.
  // The masking does not depend on src_ack, so no loop back through a source.
  assign req = (rst || !CONFIG.include_fpu || !load_en) ? '0 : src_valid;

  fp_wb_rr_select #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_select (
    .req   (req),
    .ptr   (ptr),
    .grant (grant)
  );

  assign src_ack = grant;

  // Encode the one-hot grant into an index for the data mux and pointer update.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) gnt_idx = PTR_W'(i);
    end
  end

  // Winner gets lowest priority next time: pointer moves just past it.
  assign ptr_next = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);

  // Control state: occupancy flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= |grant;
      if (|grant) ptr <= ptr_next;
    end
  end

  // Payload capture; not reset since it is only meaningful while out_valid is set.
  always_ff @(posedge clk) begin
    if (load_en && |grant) begin
      out_id   <= src_id[gnt_idx];
      out_data <= src_data[gnt_idx];
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter with two and three sources.
// Inputs change on the falling edge; acks are checked 1ns later, registers on the next falling edge.
// Expected values are hand-derived from the round-robin rules.
module tb_fp_wb_arbiter;
  import cva5_types::*;
  import fpu_types::*;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Two-source instance
  logic           rst2;
  logic [1:0]     v2;
  logic [1:0]     ack2;
  id_t            id2 [2];
  fp_wb_payload_t d2  [2];
  logic           ov2;
  logic           rdy2;
  id_t            oid2;
  fp_wb_payload_t od2;

  // Three-source instance
  logic           rst3;
  logic [2:0]     v3;
  logic [2:0]     ack3;
  id_t            id3 [3];
  fp_wb_payload_t d3  [3];
  logic           ov3;
  logic           rdy3;
  id_t            oid3;
  fp_wb_payload_t od3;

  fp_wb_arbiter #(.CONFIG(EXAMPLE_CONFIG), .NUM_SRC(2)) dut2 (
    .clk(clk), .rst(rst2), .src_valid(v2), .src_ack(ack2), .src_id(id2), .src_data(d2),
    .out_valid(ov2), .out_ready(rdy2), .out_id(oid2), .out_data(od2)
  );

  fp_wb_arbiter #(.CONFIG(EXAMPLE_CONFIG), .NUM_SRC(3)) dut3 (
    .clk(clk), .rst(rst3), .src_valid(v3), .src_ack(ack3), .src_id(id3), .src_data(d3),
    .out_valid(ov3), .out_ready(rdy3), .out_id(oid3), .out_data(od3)
  );

  function automatic fp_wb_payload_t mk(input logic [7:0] v);
    fp_wb_payload_t p;
    p.sign     = v[0];
    p.exponent = {3'b000, v};
    p.mantissa = {45'd0, v};
    p.guard    = v[1];
    p.round    = v[2];
    p.sticky   = v[3];
    p.flags    = v[4:0];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pl(input string tag, input fp_wb_payload_t obs, input fp_wb_payload_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst2 = 1'b1; rdy2 = 1'b1; v2 = 2'b11;
    id2[0] = 3'd1; d2[0] = mk(8'd1);
    id2[1] = 3'd2; d2[1] = mk(8'd2);
    rst3 = 1'b1; rdy3 = 1'b1; v3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      id3[i] = 3'd0; d3[i] = mk(8'd0);
    end

    // Reset with both sources valid: nothing acked, register empty, pointer zero
    @(negedge clk); #1;
    chk("rst_ack", 32'(ack2), 32'd0);
    chk("rst_out_valid", 32'(ov2), 32'd0);
    chk("rst_ptr", 32'(dut2.ptr), 32'd0);

    // Both valid, ready high: acks 01,10,01,10
    @(negedge clk); rst2 = 1'b0; #1;
    chk("rr_ack_a", 32'(ack2), 32'd1);
    @(negedge clk);
    chk("rr_valid_a", 32'(ov2), 32'd1);
    chk("rr_id_a", 32'(oid2), 32'd1);
    chk_pl("rr_data_a", od2, mk(8'd1));
    chk("rr_ptr_a", 32'(dut2.ptr), 32'd1);
    id2[0] = 3'd3; d2[0] = mk(8'd3); #1;
    chk("rr_ack_b", 32'(ack2), 32'd2);
    @(negedge clk);
    chk("rr_id_b", 32'(oid2), 32'd2);
    chk("rr_ptr_b", 32'(dut2.ptr), 32'd0);
    id2[1] = 3'd4; d2[1] = mk(8'd4); #1;
    chk("rr_ack_c", 32'(ack2), 32'd1);
    @(negedge clk);
    chk("rr_id_c", 32'(oid2), 32'd3);
    chk("rr_ptr_c", 32'(dut2.ptr), 32'd1);
    #1;
    chk("rr_ack_d", 32'(ack2), 32'd2);
    @(negedge clk);
    chk("rr_id_d", 32'(oid2), 32'd4);
    chk_pl("rr_data_d", od2, mk(8'd4));
    chk("rr_ptr_d", 32'(dut2.ptr), 32'd0);

    // Stall three cycles with src0 waiting: no ack, output held
    rdy2 = 1'b0; v2 = 2'b01; id2[0] = 3'd2; d2[0] = mk(8'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ack", 32'(ack2), 32'd0);
      chk("stall_valid", 32'(ov2), 32'd1);
      chk("stall_id", 32'(oid2), 32'd4);
      chk_pl("stall_data", od2, mk(8'd4));
      @(negedge clk);
    end
    rdy2 = 1'b1; #1;
    chk("unstall_ack", 32'(ack2), 32'd1);
    @(negedge clk);
    chk("unstall_id", 32'(oid2), 32'd2);
    chk_pl("unstall_data", od2, mk(8'd2));
    chk("unstall_ptr", 32'(dut2.ptr), 32'd1);

    // Nothing valid while draining: register empties, pointer kept
    v2 = 2'b00; #1;
    chk("idle_ack", 32'(ack2), 32'd0);
    @(negedge clk);
    chk("idle_valid", 32'(ov2), 32'd0);
    chk("idle_ptr", 32'(dut2.ptr), 32'd1);

    // Only src1 valid with ids 5,6,7 back-to-back: no bubbles
    v2 = 2'b10; id2[1] = 3'd5; d2[1] = mk(8'd5); #1;
    chk("b2b_ack5", 32'(ack2), 32'd2);
    @(negedge clk);
    chk("b2b_valid5", 32'(ov2), 32'd1);
    chk("b2b_id5", 32'(oid2), 32'd5);
    chk("b2b_ptr5", 32'(dut2.ptr), 32'd0);
    id2[1] = 3'd6; d2[1] = mk(8'd6); #1;
    chk("b2b_ack6", 32'(ack2), 32'd2);
    @(negedge clk);
    chk("b2b_id6", 32'(oid2), 32'd6);
    id2[1] = 3'd7; d2[1] = mk(8'd7); #1;
    chk("b2b_ack7", 32'(ack2), 32'd2);
    @(negedge clk);
    chk("b2b_valid7", 32'(ov2), 32'd1);
    chk("b2b_id7", 32'(oid2), 32'd7);
    chk_pl("b2b_data7", od2, mk(8'd7));

    // Move the pointer to 1, then reset mid-operation with src1 waiting
    v2 = 2'b01; id2[0] = 3'd1; d2[0] = mk(8'd1); #1;
    chk("pre_rst_ack", 32'(ack2), 32'd1);
    @(negedge clk);
    chk("pre_rst_valid", 32'(ov2), 32'd1);
    chk("pre_rst_ptr", 32'(dut2.ptr), 32'd1);
    v2 = 2'b10; id2[1] = 3'd3; d2[1] = mk(8'd3); rst2 = 1'b1; #1;
    chk("mid_rst_ack", 32'(ack2), 32'd0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(ov2), 32'd0);
    chk("mid_rst_ptr", 32'(dut2.ptr), 32'd0);
    #1;
    chk("mid_rst_ack2", 32'(ack2), 32'd0);
    rst2 = 1'b0; v2 = 2'b00;

    // Three sources all valid: grant order 0,1,2,0
    chk("n3_rst_valid", 32'(ov3), 32'd0);
    v3 = 3'b111;
    id3[0] = 3'd1; d3[0] = mk(8'd1);
    id3[1] = 3'd2; d3[1] = mk(8'd2);
    id3[2] = 3'd3; d3[2] = mk(8'd3);
    rst3 = 1'b0; #1;
    chk("n3_ack_a", 32'(ack3), 32'd1);
    @(negedge clk);
    chk("n3_id_a", 32'(oid3), 32'd1);
    chk("n3_ptr_a", 32'(dut3.ptr), 32'd1);
    id3[0] = 3'd4; d3[0] = mk(8'd4); #1;
    chk("n3_ack_b", 32'(ack3), 32'd2);
    @(negedge clk);
    chk("n3_id_b", 32'(oid3), 32'd2);
    chk("n3_ptr_b", 32'(dut3.ptr), 32'd2);
    id3[1] = 3'd5; d3[1] = mk(8'd5); #1;
    chk("n3_ack_c", 32'(ack3), 32'd4);
    @(negedge clk);
    chk("n3_id_c", 32'(oid3), 32'd3);
    chk("n3_ptr_c", 32'(dut3.ptr), 32'd0);
    id3[2] = 3'd6; d3[2] = mk(8'd6); #1;
    chk("n3_ack_d", 32'(ack3), 32'd1);
    @(negedge clk);
    chk("n3_id_d", 32'(oid3), 32'd4);
    chk_pl("n3_data_d", od3, mk(8'd4));
    chk("n3_ptr_d", 32'(dut3.ptr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
